// File: rtl/stack_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : stack_pkg
//  Description : Shared types and helpers for the parametrised command-driven
//                stack: command encoding and modular pointer arithmetic.
//  Revision    : 1.0 - initial release
// ============================================================================
package stack_pkg;

  // 2-bit command bus encoding
  typedef enum logic [1:0] {
    CMD_NOP  = 2'b00,
    CMD_PUSH = 2'b01,
    CMD_POP  = 2'b10,
    CMD_GET  = 2'b11
  } cmd_e;

  // (ptr - n) mod depth, valid for any n; ptr is assumed < depth.
  function automatic int unsigned wrap_dec(input int unsigned ptr,
                                           input int unsigned n,
                                           input int unsigned depth);
    return (ptr + depth - (n % depth)) % depth;
  endfunction

endpackage
`default_nettype wire

// File: rtl/stack_ring_mem.sv
`default_nettype none
// ============================================================================
//  Module      : stack_ring_mem
//  Description : DEPTH x DATA_W register array, one synchronous write port and
//                one combinational read port. Contents are never reset.
//  Ports       : clk      - write clock
//                i_we     - write enable
//                i_waddr  - write slot
//                i_wdata  - write data
//                i_raddr  - read slot
//                o_rdata  - read data (combinational)
//  Revision    : 1.0 - initial release
// ============================================================================
module stack_ring_mem #(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 5,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [IDX_W-1:0]  i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/stack_param.sv
`default_nettype none
// ============================================================================
//  Module      : stack_param
//  Description : Parametrised command-driven stack on a circular buffer with a
//                registered read path, status flags and an error pulse.
//  Ports       : CLK      - clock, rising edge
//                RESET    - asynchronous active-high reset
//                COMMAND  - NOP / PUSH / POP / GET
//                INDEX    - GET depth below top (0 = top)
//                I_DATA   - PUSH data
//                O_DATA   - registered POP/GET result
//                O_VALID  - one-cycle strobe for a successful POP/GET
//                FULL     - COUNT == DEPTH
//                EMPTY    - COUNT == 0
//                COUNT    - number of valid entries
//                ERR      - one-cycle pulse for a rejected command
//  Revision    : 1.0 - initial release
// ============================================================================
module stack_param
  import stack_pkg::*;
#(
  parameter  int DATA_W    = 4,
  parameter  int DEPTH     = 5,
  parameter  int OVERWRITE = 0,
  localparam int IDX_W     = $clog2(DEPTH),
  localparam int CNT_W     = $clog2(DEPTH + 1)
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [1:0]        COMMAND,
  input  logic [IDX_W-1:0]  INDEX,
  input  logic [DATA_W-1:0] I_DATA,
  output logic [DATA_W-1:0] O_DATA,
  output logic              O_VALID,
  output logic              FULL,
  output logic              EMPTY,
  output logic [CNT_W-1:0]  COUNT,
  output logic              ERR
);

  logic [IDX_W-1:0]  r_top;    // next free slot
  logic [CNT_W-1:0]  r_count;
  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic              r_err;

  cmd_e              w_cmd;
  logic              w_full;
  logic              w_empty;
  logic              w_idx_ok;
  logic              w_we;
  logic [IDX_W-1:0]  w_raddr;
  logic [DATA_W-1:0] w_rdata;
  logic [IDX_W-1:0]  w_top_inc;
  logic [IDX_W-1:0]  w_top_dec;
  logic [IDX_W-1:0]  w_top_nxt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [DATA_W-1:0] w_data_nxt;
  logic              w_valid_nxt;
  logic              w_err_nxt;

  assign w_cmd     = cmd_e'(COMMAND);
  assign w_full    = (r_count == CNT_W'(DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_idx_ok  = (32'(INDEX) < 32'(r_count));
  assign w_top_inc = (r_top == IDX_W'(DEPTH - 1)) ? '0 : r_top + IDX_W'(1);
  assign w_top_dec = IDX_W'(wrap_dec(32'(r_top), 1, DEPTH));

  // When full, r_top already points at the oldest entry, so an overwriting
  // PUSH uses the same write path and simply leaves COUNT at DEPTH.
  always_comb begin
    w_we        = 1'b0;
    w_raddr     = w_top_dec;
    w_top_nxt   = r_top;
    w_cnt_nxt   = r_count;
    w_data_nxt  = r_data;
    w_valid_nxt = 1'b0;
    w_err_nxt   = 1'b0;
    case (w_cmd)
      CMD_PUSH: begin
        if (!w_full || (OVERWRITE != 0)) begin
          w_we      = 1'b1;
          w_top_nxt = w_top_inc;
          if (!w_full) begin
            w_cnt_nxt = r_count + CNT_W'(1);
          end
        end else begin
          w_err_nxt = 1'b1;
        end
      end
      CMD_POP: begin
        if (!w_empty) begin
          w_data_nxt  = w_rdata;
          w_top_nxt   = w_top_dec;
          w_cnt_nxt   = r_count - CNT_W'(1);
          w_valid_nxt = 1'b1;
        end else begin
          w_err_nxt = 1'b1;
        end
      end
      CMD_GET: begin
        w_raddr = IDX_W'(wrap_dec(32'(r_top), 32'(INDEX) + 1, DEPTH));
        if (w_idx_ok) begin
          w_data_nxt  = w_rdata;
          w_valid_nxt = 1'b1;
        end else begin
          w_err_nxt = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_top   <= '0;
      r_count <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_top   <= w_top_nxt;
      r_count <= w_cnt_nxt;
      r_data  <= w_data_nxt;
      r_valid <= w_valid_nxt;
      r_err   <= w_err_nxt;
    end
  end

  stack_ring_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_mem (
    .clk     (CLK),
    .i_we    (w_we && !RESET),
    .i_waddr (r_top),
    .i_wdata (I_DATA),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  assign O_DATA  = r_data;
  assign O_VALID = r_valid;
  assign ERR     = r_err;
  assign COUNT   = r_count;
  assign FULL    = w_full;
  assign EMPTY   = w_empty;

endmodule
`default_nettype wire

// File: tb/tb_stack_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stack_param
//  Description : Self-checking bench for stack_param. Two instances share one
//                command stream, one rejecting PUSH on full and one
//                overwriting. A queue-based stack model predicts each result,
//                which is pushed to a per-instance scoreboard and compared
//                after the clock edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stack_param;

  typedef struct packed {
    logic [3:0] data;
    logic       valid;
    logic       err;
    logic       full;
    logic       empty;
    logic [2:0] count;
  } exp_t;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [1:0] COMMAND;
  logic [2:0] INDEX;
  logic [3:0] I_DATA;

  logic [3:0] o_data0, o_data1;
  logic       o_valid0, o_valid1, full0, full1, empty0, empty1, err0, err1;
  logic [2:0] count0, count1;

  int n_checks = 0;
  int n_fails  = 0;

  logic [3:0] mq0[$];
  logic [3:0] mq1[$];
  logic [3:0] md0, md1;
  exp_t       sb0[$];
  exp_t       sb1[$];

  always #5 CLK = ~CLK;

  stack_param #(.DATA_W(4), .DEPTH(5), .OVERWRITE(0)) u_dut0 (
    .CLK(CLK), .RESET(RESET), .COMMAND(COMMAND), .INDEX(INDEX), .I_DATA(I_DATA),
    .O_DATA(o_data0), .O_VALID(o_valid0), .FULL(full0), .EMPTY(empty0),
    .COUNT(count0), .ERR(err0)
  );

  stack_param #(.DATA_W(4), .DEPTH(5), .OVERWRITE(1)) u_dut1 (
    .CLK(CLK), .RESET(RESET), .COMMAND(COMMAND), .INDEX(INDEX), .I_DATA(I_DATA),
    .O_DATA(o_data1), .O_VALID(o_valid1), .FULL(full1), .EMPTY(empty1),
    .COUNT(count1), .ERR(err1)
  );

  task automatic chk(input string tag, input int m, input logic [7:0] obs,
                     input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s dut%0d: observed %0h expected %0h", tag, m, obs, exp);
    end
  endtask

  task automatic compare(input int m, input exp_t e);
    exp_t o;
    if (m == 0) o = '{o_data0, o_valid0, err0, full0, empty0, count0};
    else        o = '{o_data1, o_valid1, err1, full1, empty1, count1};
    chk("O_DATA",  m, 8'(o.data),  8'(e.data));
    chk("O_VALID", m, 8'(o.valid), 8'(e.valid));
    chk("ERR",     m, 8'(o.err),   8'(e.err));
    chk("FULL",    m, 8'(o.full),  8'(e.full));
    chk("EMPTY",   m, 8'(o.empty), 8'(e.empty));
    chk("COUNT",   m, 8'(o.count), 8'(e.count));
  endtask

  // Reference model: queue back = top of stack, front = oldest entry.
  task automatic model(input int m, input logic [1:0] cmd, input int idx,
                       input logic [3:0] din);
    logic [3:0] q[$];
    logic [3:0] d;
    logic       v, e;
    if (m == 0) begin q = mq0; d = md0; end
    else        begin q = mq1; d = md1; end
    v = 1'b0;
    e = 1'b0;
    case (cmd)
      2'b01: begin
        if (q.size() < 5) q.push_back(din);
        else if (m == 1) begin void'(q.pop_front()); q.push_back(din); end
        else e = 1'b1;
      end
      2'b10: begin
        if (q.size() > 0) begin d = q.pop_back(); v = 1'b1; end
        else e = 1'b1;
      end
      2'b11: begin
        if (idx < q.size()) begin d = q[q.size() - 1 - idx]; v = 1'b1; end
        else e = 1'b1;
      end
      default: ;
    endcase
    if (m == 0) begin
      mq0 = q; md0 = d;
      sb0.push_back('{d, v, e, q.size() == 5, q.size() == 0, 3'(q.size())});
    end else begin
      mq1 = q; md1 = d;
      sb1.push_back('{d, v, e, q.size() == 5, q.size() == 0, 3'(q.size())});
    end
  endtask

  task automatic step(input logic [1:0] cmd, input int idx, input logic [3:0] din);
    COMMAND = cmd;
    INDEX   = 3'(idx);
    I_DATA  = din;
    model(0, cmd, idx, din);
    model(1, cmd, idx, din);
    @(posedge CLK);
    #1;
    compare(0, sb0.pop_front());
    compare(1, sb1.pop_front());
  endtask

  // Asserts reset between clock edges, checks the immediate reset state,
  // then releases it before the next rising edge.
  task automatic mid_cycle_reset();
    #2;
    RESET = 1'b1;
    #1;
    mq0.delete(); mq1.delete();
    md0 = '0; md1 = '0;
    compare(0, '{4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0});
    compare(1, '{4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0});
    #2;
    RESET = 1'b0;
  endtask

  initial begin
    RESET   = 1'b1;
    COMMAND = 2'b00;
    INDEX   = '0;
    I_DATA  = '0;
    md0 = '0;
    md1 = '0;
    #1;
    compare(0, '{4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0});
    compare(1, '{4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0});
    @(posedge CLK);
    #3;
    RESET = 1'b0;

    // 1: fill, then read every depth
    for (int i = 1; i <= 5; i++) step(2'b01, 0, 4'(i));
    for (int i = 0; i < 5; i++)  step(2'b11, i, 4'd0);
    step(2'b00, 0, 4'd0);

    // 2/3: PUSH on full - dut0 rejects, dut1 overwrites oldest
    step(2'b01, 0, 4'd6);
    step(2'b11, 0, 4'd0);
    step(2'b11, 4, 4'd0);

    // 4: drain past empty
    for (int i = 0; i < 6; i++) step(2'b10, 0, 4'd0);
    step(2'b00, 0, 4'd0);

    // 5: partial fill and out-of-range GETs
    step(2'b01, 0, 4'd9);
    step(2'b01, 0, 4'd10);
    step(2'b11, 1, 4'd0);
    step(2'b11, 2, 4'd0);
    step(2'b11, 7, 4'd0);

    // 6: asynchronous reset with three entries held
    step(2'b01, 0, 4'd3);
    mid_cycle_reset();
    step(2'b10, 0, 4'd0);
    step(2'b01, 0, 4'd4);
    step(2'b11, 0, 4'd0);

    // Wrap-around stress: overwrite several times then read back
    for (int i = 0; i < 12; i++) step(2'b01, 0, 4'(i + 3));
    for (int i = 0; i < 5; i++)  step(2'b11, i, 4'd0);
    for (int i = 0; i < 3; i++)  step(2'b10, 0, 4'd0);
    step(2'b11, 1, 4'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
